// File: rtl/video_timing_pkg.sv
// Shared constants and types for the video timing controller.
//   - 720p default horizontal/vertical timing (H_*, V_*)
//   - CNT_W: width of the h/v position counters
//   - vtc_state_t: sequencer FSM state
package video_timing_pkg;

  localparam int unsigned H_SYNC  = 40;
  localparam int unsigned H_BACK  = 220;
  localparam int unsigned H_DISP  = 1280;
  localparam int unsigned H_FRONT = 110;
  localparam int unsigned H_TOTAL = 1650;

  localparam int unsigned V_SYNC  = 5;
  localparam int unsigned V_BACK  = 20;
  localparam int unsigned V_DISP  = 720;
  localparam int unsigned V_FRONT = 5;
  localparam int unsigned V_TOTAL = 750;

  localparam int unsigned CNT_W   = 11;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    STOP_PEND = 2'd2
  } vtc_state_t;

endpackage

// File: rtl/video_hv_counter.sv
// Horizontal/vertical raster position counters.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   en           advance when high; when low the counters are held at (0,0)
//   h_cnt, v_cnt current raster position
//   last         high at the final position (H_TOTAL-1, V_TOTAL-1)
module video_hv_counter
  import video_timing_pkg::*;
#(
  parameter int unsigned H_TOTAL = video_timing_pkg::H_TOTAL,
  parameter int unsigned V_TOTAL = video_timing_pkg::V_TOTAL,
  parameter int unsigned CNT_W   = video_timing_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             last
);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  logic h_wrap;

  assign h_wrap = (h_cnt == H_LAST);
  assign last   = h_wrap && (v_cnt == V_LAST);

  // Holding at zero while disabled guarantees the first enabled cycle sits at (0,0).
  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      if (h_wrap) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
      end else begin
        h_cnt <= h_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/video_timing_ctrl.sv
// Frame sequencer feeding the pre_img_* input of the laplacian filter.
// Generates vsync/hsync/valid from raster counters and pulls pixels from an
// upstream source through a same-cycle request/ready handshake.
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   en               run request (level); start/stop only at frame boundaries
//   clr_err          clears the sticky underflow flag
//   pix_req          high while the raster is inside the active window
//   pix_rdy/pix_data source pixel, valid in the same cycle as pix_req
//   post_img_*       registered timing/pixel stream (1 clock latency)
//   frame_done       pulse aligned with the last beat of a frame
//   busy             high when not idle
//   underflow        sticky: an active slot found the source not ready
module video_timing_ctrl
  import video_timing_pkg::*;
#(
  parameter int unsigned H_SYNC  = video_timing_pkg::H_SYNC,
  parameter int unsigned H_BACK  = video_timing_pkg::H_BACK,
  parameter int unsigned H_DISP  = video_timing_pkg::H_DISP,
  parameter int unsigned H_FRONT = video_timing_pkg::H_FRONT,
  parameter int unsigned H_TOTAL = video_timing_pkg::H_TOTAL,
  parameter int unsigned V_SYNC  = video_timing_pkg::V_SYNC,
  parameter int unsigned V_BACK  = video_timing_pkg::V_BACK,
  parameter int unsigned V_DISP  = video_timing_pkg::V_DISP,
  parameter int unsigned V_FRONT = video_timing_pkg::V_FRONT,
  parameter int unsigned V_TOTAL = video_timing_pkg::V_TOTAL,
  parameter int unsigned CNT_W   = video_timing_pkg::CNT_W
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr_err,
  output logic       pix_req,
  input  logic       pix_rdy,
  input  logic [7:0] pix_data,
  output logic       post_img_vsync,
  output logic       post_img_hsync,
  output logic       post_img_valid,
  output logic [7:0] post_img_data,
  output logic       frame_done,
  output logic       busy,
  output logic       underflow
);

  if (H_TOTAL != H_SYNC + H_BACK + H_DISP + H_FRONT) begin : g_bad_h_total
    $error("H_TOTAL must equal H_SYNC+H_BACK+H_DISP+H_FRONT");
  end
  if (V_TOTAL != V_SYNC + V_BACK + V_DISP + V_FRONT) begin : g_bad_v_total
    $error("V_TOTAL must equal V_SYNC+V_BACK+V_DISP+V_FRONT");
  end
  if ((64'd1 << CNT_W) < 64'(H_TOTAL) || (64'd1 << CNT_W) < 64'(V_TOTAL)) begin : g_bad_cnt_w
    $error("CNT_W too narrow for H_TOTAL/V_TOTAL");
  end

  localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] H_ACT_LO   = CNT_W'(H_SYNC + H_BACK);
  localparam logic [CNT_W-1:0] H_ACT_HI   = CNT_W'(H_SYNC + H_BACK + H_DISP);
  localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] V_ACT_LO   = CNT_W'(V_SYNC + V_BACK);
  localparam logic [CNT_W-1:0] V_ACT_HI   = CNT_W'(V_SYNC + V_BACK + V_DISP);

  vtc_state_t       state_q;
  vtc_state_t       state_d;
  logic             running;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             last_pos;
  logic             vs;
  logic             hs;
  logic             act;

  video_hv_counter #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL),
    .CNT_W   (CNT_W)
  ) u_hv_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (running),
    .h_cnt (h_cnt),
    .v_cnt (v_cnt),
    .last  (last_pos)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (en) state_d = RUN;
      RUN:       if (!en) state_d = STOP_PEND;
      STOP_PEND: begin
        if (en) begin
          state_d = RUN;
        end else if (last_pos) begin
          state_d = IDLE;
        end
      end
      default:   state_d = IDLE;
    endcase
  end

  // State-derived outputs
  always_comb begin
    running = (state_q != IDLE);
    busy    = running;
  end

  // Raster decode; gated by running because (0,0) in IDLE would otherwise
  // decode as sync active.
  always_comb begin
    vs      = running && (v_cnt < V_SYNC_END);
    hs      = running && (h_cnt < H_SYNC_END);
    act     = running &&
              (h_cnt >= H_ACT_LO) && (h_cnt < H_ACT_HI) &&
              (v_cnt >= V_ACT_LO) && (v_cnt < V_ACT_HI);
    pix_req = act;
  end

  // Output stage: one clock behind the counters; frame_done lines up with
  // the beat for the last raster position.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      post_img_vsync <= 1'b0;
      post_img_hsync <= 1'b0;
      post_img_valid <= 1'b0;
      post_img_data  <= '0;
      frame_done     <= 1'b0;
      underflow      <= 1'b0;
    end else begin
      post_img_vsync <= vs;
      post_img_hsync <= hs;
      post_img_valid <= act;
      post_img_data  <= (act && pix_rdy) ? pix_data : '0;
      frame_done     <= running && last_pos;
      if (act && !pix_rdy) begin
        underflow <= 1'b1;
      end else if (clr_err) begin
        underflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_video_timing_ctrl.sv
module tb_video_timing_ctrl;

  localparam int HS = 2, HB = 1, HD = 4, HF = 1, HT = 8;
  localparam int VS = 1, VB = 1, VD = 3, VF = 1, VT = 6;
  localparam int FR = HT * VT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       clr_err = 1'b0;
  logic       pix_rdy = 1'b0;
  logic [7:0] pix_data = 8'h00;
  logic       pix_req;
  logic       post_img_vsync, post_img_hsync, post_img_valid;
  logic [7:0] post_img_data;
  logic       frame_done, busy, underflow;

  video_timing_ctrl #(
    .H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF), .H_TOTAL(HT),
    .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF), .V_TOTAL(VT),
    .CNT_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr_err(clr_err),
    .pix_req(pix_req), .pix_rdy(pix_rdy), .pix_data(pix_data),
    .post_img_vsync(post_img_vsync), .post_img_hsync(post_img_hsync),
    .post_img_valid(post_img_valid), .post_img_data(post_img_data),
    .frame_done(frame_done), .busy(busy), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       vs;
    logic       hs;
    logic       valid;
    logic [7:0] data;
    logic       fd;
    logic       busy;
    logic       uf;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: a linear position within the frame plus run/stop flags.
  bit   m_active = 0;
  bit   m_stop   = 0;
  bit   m_uf     = 0;
  int   m_pos    = 0;
  int   pix_ctr  = 0;

  function automatic bit f_act(input int p);
    int h, v;
    h = p % HT;
    v = p / HT;
    return (h >= HS + HB) && (h < HS + HB + HD) && (v >= VS + VB) && (v < VS + VB + VD);
  endfunction

  task automatic chk(input string n, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0h exp %0h", n, $time, got, exp);
    end
  endtask

  // One clock of stimulus: drive, check pix_req, predict the next output beat.
  task automatic cycle(input bit i_rst_n, input bit i_en, input bit i_rdy,
                       input logic [7:0] i_data, input bit i_clr);
    exp_t e;
    bit   a;
    @(negedge clk);
    rst_n = i_rst_n; en = i_en; pix_rdy = i_rdy; pix_data = i_data; clr_err = i_clr;
    a = m_active && f_act(m_pos);
    chk("pix_req", {7'd0, pix_req}, {7'd0, a});
    e = '0;
    if (!i_rst_n) begin
      m_active = 0; m_stop = 0; m_pos = 0; m_uf = 0;
    end else begin
      if (m_active) begin
        e.vs    = (m_pos / HT) < VS;
        e.hs    = (m_pos % HT) < HS;
        e.valid = a;
        e.data  = (a && i_rdy) ? i_data : 8'h00;
        e.fd    = (m_pos == FR - 1);
      end
      if (a && i_rdy) pix_ctr++;
      if (a && !i_rdy) m_uf = 1;
      else if (i_clr) m_uf = 0;
      if (!m_active) begin
        if (i_en) begin
          m_active = 1; m_stop = 0; m_pos = 0;
        end
      end else begin
        if (!m_stop) m_stop = !i_en;
        else if (i_en) m_stop = 0;
        else if (m_pos == FR - 1) m_active = 0;
        m_pos = m_active ? (m_pos + 1) % FR : 0;
      end
    end
    e.uf   = m_uf;
    e.busy = m_active;
    q.push_back(e);
  endtask

  // Advance until the model's next cycle is frame position p.
  task automatic wait_pos(input int p, input bit i_en);
    int n;
    n = 0;
    while (!(m_active && m_pos == p) && n < 200) begin
      cycle(1, i_en, 1, 8'(pix_ctr), 0);
      n++;
    end
    checks++;
    if (!(m_active && m_pos == p)) begin
      errors++;
      $display("FAIL wait_pos got %0d exp %0d", m_pos, p);
    end
  endtask

  // Monitor: every clock the DUT presents one beat; compare against the queue.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("vsync",      {7'd0, post_img_vsync}, {7'd0, e.vs});
        chk("hsync",      {7'd0, post_img_hsync}, {7'd0, e.hs});
        chk("valid",      {7'd0, post_img_valid}, {7'd0, e.valid});
        chk("data",       post_img_data,          e.data);
        chk("frame_done", {7'd0, frame_done},     {7'd0, e.fd});
        chk("busy",       {7'd0, busy},           {7'd0, e.busy});
        chk("underflow",  {7'd0, underflow},      {7'd0, e.uf});
      end
    end
  end

  initial begin
    bit en_r;
    // Reset
    repeat (3) cycle(0, 0, 1, 8'h00, 0);
    // First frame with incrementing source data 0x00..
    pix_ctr = 0;
    repeat (FR + 2) cycle(1, 1, 1, 8'(pix_ctr), 0);
    // Stop requested mid-frame: frame completes, then idle
    wait_pos(20, 1);
    repeat (60) cycle(1, 0, 1, 8'(pix_ctr), 0);
    // Stop requested then cancelled: frames continue back to back
    cycle(1, 1, 1, 8'(pix_ctr), 0);
    wait_pos(10, 1);
    wait_pos(30, 0);
    repeat (FR + 10) cycle(1, 1, 1, 8'(pix_ctr), 0);
    // Underflow on 2nd active pixel of 1st active line, clear, clear vs set
    wait_pos(20, 1);
    cycle(1, 1, 0, 8'h5A, 0);
    wait_pos(30, 1);
    cycle(1, 1, 1, 8'(pix_ctr), 1);
    wait_pos(36, 1);
    cycle(1, 1, 0, 8'h77, 1);
    repeat (5) cycle(1, 1, 1, 8'(pix_ctr), 0);
    // Reset mid-frame with en held, then restart from (0,0)
    wait_pos(25, 1);
    cycle(0, 1, 1, 8'(pix_ctr), 0);
    repeat (FR + 5) cycle(1, 1, 1, 8'(pix_ctr), 0);
    // Randomized traffic
    en_r = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) en_r = ~en_r;
      cycle(($urandom_range(0, 199) != 0), en_r, ($urandom_range(0, 15) != 0),
            8'($urandom_range(0, 255)), ($urandom_range(0, 19) == 0));
    end
    repeat (3) cycle(1, 0, 1, 8'h00, 0);
    @(posedge clk);
    #3;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d exp 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
